// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the 8259A-compatible interrupt-service sequencer.
//   - NUM_IR            : number of interrupt levels (fixed at 8)
//   - ST_*              : acknowledge-sequence state encodings
//   - OCW2_*            : OCW2 {R, SL, EOI} command codes
//   - rotate_find_highest(bits, pointer) -> {found, level}
// ---------------------------------------------------------------------------
package pic_pkg;

    localparam int unsigned NUM_IR = 8;

    // Acknowledge-sequence states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK1 = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_ACK2 = 2'd3;

    // OCW2 command codes, bit order {R, SL, EOI}
    localparam logic [2:0] OCW2_CLR_ROT_AEOI = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_S_EOI        = 3'b011;
    localparam logic [2:0] OCW2_SET_ROT_AEOI = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_S_EOI    = 3'b111;

    // Highest-priority set bit when level (pointer+1) is highest and the
    // pointer level itself is lowest. Returns {found, level}.
    function automatic logic [3:0] rotate_find_highest(input logic [7:0] bits,
                                                       input logic [2:0] pointer);
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'b0000;
        // Scan from lowest to highest priority so the highest hit is the last one kept.
        for (int i = 7; i >= 0; i--) begin
            lvl = pointer + 3'(i + 1);
            if (bits[lvl]) begin
                res = {1'b1, lvl};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pic_service_sequencer_if.sv
// ---------------------------------------------------------------------------
// pic_service_sequencer_if
// Bundles the request/mask inputs, command strobes, INTA handshake and the
// vector/ISR outputs of the service sequencer.
//   master : the surrounding PIC (request/mask regs, command decode, bus buffer)
//   slave  : pic_service_sequencer
// ---------------------------------------------------------------------------
interface pic_service_sequencer_if;

    logic       init_strobe;
    logic [7:0] irr;
    logic [7:0] imr;
    logic       special_mask_mode;
    logic       aeoi_mode;
    logic [4:0] vector_base;
    logic       inta_n;
    logic       ocw2_strobe;
    logic [2:0] ocw2_cmd;
    logic [2:0] ocw2_level;
    logic       int_out;
    logic [7:0] isr;
    logic [7:0] irr_clear;
    logic [7:0] vector_out;
    logic       vector_valid;

    modport master (
        output init_strobe, irr, imr, special_mask_mode, aeoi_mode, vector_base,
               inta_n, ocw2_strobe, ocw2_cmd, ocw2_level,
        input  int_out, isr, irr_clear, vector_out, vector_valid
    );

    modport slave (
        input  init_strobe, irr, imr, special_mask_mode, aeoi_mode, vector_base,
               inta_n, ocw2_strobe, ocw2_cmd, ocw2_level,
        output int_out, isr, irr_clear, vector_out, vector_valid
    );

endinterface

// File: rtl/pic_priority_resolver.sv
// ---------------------------------------------------------------------------
// pic_priority_resolver
// Combinational rotating-priority resolver.
//   i_candidates   : levels competing for service
//   i_blocking     : in-service levels that block equal/lower priorities
//   i_pointer      : lowest-priority level; (i_pointer+1) is highest
//   o_winner_valid : a candidate beats every blocking level
//   o_winner_level : that candidate's level
//   o_isr_valid    : some blocking level is set
//   o_isr_level    : highest-priority blocking level
// ---------------------------------------------------------------------------
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] i_candidates,
    input  logic [7:0] i_blocking,
    input  logic [2:0] i_pointer,
    output logic       o_winner_valid,
    output logic [2:0] o_winner_level,
    output logic       o_isr_valid,
    output logic [2:0] o_isr_level
);

    logic [3:0] w_cand;
    logic [3:0] w_blk;
    logic [2:0] w_cand_rank;
    logic [2:0] w_blk_rank;

    assign w_cand = rotate_find_highest(i_candidates, i_pointer);
    assign w_blk  = rotate_find_highest(i_blocking, i_pointer);

    // Rank 0 is the highest priority: distance from (pointer+1), modulo 8.
    assign w_cand_rank = w_cand[2:0] - i_pointer - 3'd1;
    assign w_blk_rank  = w_blk[2:0] - i_pointer - 3'd1;

    assign o_winner_valid = w_cand[3] & (~w_blk[3] | (w_cand_rank < w_blk_rank));
    assign o_winner_level = w_cand[2:0];
    assign o_isr_valid    = w_blk[3];
    assign o_isr_level    = w_blk[2:0];

endmodule

// File: rtl/pic_service_sequencer.sv
// ---------------------------------------------------------------------------
// pic_service_sequencer
// Owns the ISR, the rotating priority pointer and the two-pulse INTA
// sequence of an 8259A-compatible PIC.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : pic_service_sequencer_if.slave
//     in  : init_strobe, irr, imr, special_mask_mode, aeoi_mode, vector_base,
//           inta_n, ocw2_strobe, ocw2_cmd, ocw2_level
//     out : int_out, isr, irr_clear, vector_out, vector_valid
// ---------------------------------------------------------------------------
module pic_service_sequencer
    import pic_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    pic_service_sequencer_if.slave bus
);

    // State
    logic [1:0] r_state;
    logic [7:0] r_isr;
    logic [2:0] r_ptr;
    logic       r_rot_aeoi;
    logic       r_inta_q;
    logic       r_int_out;
    logic [7:0] r_irr_clear;
    logic [7:0] r_vector_out;
    logic       r_vector_valid;
    logic [2:0] r_level;
    logic       r_spurious;

    // Next-state / combinational
    logic [1:0] w_state_d;
    logic [7:0] w_isr_set;
    logic [7:0] w_isr_clr;
    logic [7:0] w_isr_d;
    logic [2:0] w_ptr_d;
    logic       w_rot_aeoi_d;
    logic       w_int_out_d;
    logic [7:0] w_vector_out_d;
    logic       w_vector_valid_d;
    logic [2:0] w_level_d;
    logic       w_spurious_d;

    logic       w_inta_fall;
    logic       w_inta_rise;
    logic [7:0] w_candidates;
    logic [7:0] w_blocking;
    logic       w_win_valid;
    logic [2:0] w_win_level;
    logic       w_hi_isr_valid;
    logic [2:0] w_hi_isr_level;

    logic       w_unused_req_isr_valid;
    logic [2:0] w_unused_req_isr_level;
    logic       w_unused_eoi_win_valid;
    logic [2:0] w_unused_eoi_win_level;

    assign w_inta_fall  = r_inta_q & ~bus.inta_n;
    assign w_inta_rise  = ~r_inta_q & bus.inta_n;
    assign w_candidates = bus.irr & ~bus.imr;
    // In special mask mode a masked in-service level no longer blocks others.
    assign w_blocking   = bus.special_mask_mode ? (r_isr & ~bus.imr) : r_isr;

    // Request arbitration
    pic_priority_resolver u_req_resolver (
        .i_candidates   (w_candidates),
        .i_blocking     (w_blocking),
        .i_pointer      (r_ptr),
        .o_winner_valid (w_win_valid),
        .o_winner_level (w_win_level),
        .o_isr_valid    (w_unused_req_isr_valid),
        .o_isr_level    (w_unused_req_isr_level)
    );

    // Highest in-service level for non-specific EOI (full ISR, pre-update)
    pic_priority_resolver u_eoi_resolver (
        .i_candidates   (8'h00),
        .i_blocking     (r_isr),
        .i_pointer      (r_ptr),
        .o_winner_valid (w_unused_eoi_win_valid),
        .o_winner_level (w_unused_eoi_win_level),
        .o_isr_valid    (w_hi_isr_valid),
        .o_isr_level    (w_hi_isr_level)
    );

    always_comb begin
        w_state_d        = r_state;
        w_isr_set        = 8'h00;
        w_isr_clr        = 8'h00;
        w_ptr_d          = r_ptr;
        w_rot_aeoi_d     = r_rot_aeoi;
        w_vector_out_d   = r_vector_out;
        w_vector_valid_d = r_vector_valid;
        w_level_d        = r_level;
        w_spurious_d     = r_spurious;

        case (r_state)
            ST_IDLE: begin
                if (w_inta_fall) begin
                    w_state_d = ST_ACK1;
                    if (w_win_valid) begin
                        w_isr_set    = 8'h01 << w_win_level;
                        w_level_d    = w_win_level;
                        w_spurious_d = 1'b0;
                    end else begin
                        // Spurious acknowledge: the CPU still gets an IR7 vector.
                        w_level_d    = 3'd7;
                        w_spurious_d = 1'b1;
                    end
                end
            end
            ST_ACK1: begin
                if (w_inta_rise) begin
                    w_state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_inta_fall) begin
                    w_state_d        = ST_ACK2;
                    w_vector_out_d   = {bus.vector_base, r_level};
                    w_vector_valid_d = 1'b1;
                end
            end
            ST_ACK2: begin
                if (w_inta_rise) begin
                    w_state_d        = ST_IDLE;
                    w_vector_valid_d = 1'b0;
                    // No ISR bit was set for a spurious acknowledge, so nothing to retire.
                    if (bus.aeoi_mode && !r_spurious) begin
                        w_isr_clr = 8'h01 << r_level;
                        if (r_rot_aeoi) begin
                            w_ptr_d = r_level;
                        end
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        if (bus.ocw2_strobe) begin
            case (bus.ocw2_cmd)
                OCW2_NS_EOI: begin
                    if (w_hi_isr_valid) begin
                        w_isr_clr = w_isr_clr | (8'h01 << w_hi_isr_level);
                    end
                end
                OCW2_ROT_NS_EOI: begin
                    if (w_hi_isr_valid) begin
                        w_isr_clr = w_isr_clr | (8'h01 << w_hi_isr_level);
                        w_ptr_d   = w_hi_isr_level;
                    end
                end
                OCW2_S_EOI: begin
                    w_isr_clr = w_isr_clr | (8'h01 << bus.ocw2_level);
                end
                OCW2_ROT_S_EOI: begin
                    w_isr_clr = w_isr_clr | (8'h01 << bus.ocw2_level);
                    w_ptr_d   = bus.ocw2_level;
                end
                OCW2_SET_PRIO: begin
                    w_ptr_d = bus.ocw2_level;
                end
                OCW2_SET_ROT_AEOI: begin
                    w_rot_aeoi_d = 1'b1;
                end
                OCW2_CLR_ROT_AEOI: begin
                    w_rot_aeoi_d = 1'b0;
                end
                default: begin
                    // OCW2_NOP
                end
            endcase
        end

        // A set in the same cycle as a clear of the same bit wins.
        w_isr_d     = (r_isr & ~w_isr_clr) | w_isr_set;
        w_int_out_d = (w_state_d == ST_IDLE) & w_win_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_isr          <= 8'h00;
            r_ptr          <= 3'd7;
            r_rot_aeoi     <= 1'b0;
            r_inta_q       <= 1'b1;
            r_int_out      <= 1'b0;
            r_irr_clear    <= 8'h00;
            r_vector_out   <= 8'h00;
            r_vector_valid <= 1'b0;
            r_level        <= 3'd0;
            r_spurious     <= 1'b0;
        end else if (bus.init_strobe) begin
            r_state        <= ST_IDLE;
            r_isr          <= 8'h00;
            r_ptr          <= 3'd7;
            r_rot_aeoi     <= 1'b0;
            // Keep tracking the pin so a low INTA during init is not seen as a new fall.
            r_inta_q       <= bus.inta_n;
            r_int_out      <= 1'b0;
            r_irr_clear    <= 8'h00;
            r_vector_out   <= 8'h00;
            r_vector_valid <= 1'b0;
            r_level        <= 3'd0;
            r_spurious     <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_isr          <= w_isr_d;
            r_ptr          <= w_ptr_d;
            r_rot_aeoi     <= w_rot_aeoi_d;
            r_inta_q       <= bus.inta_n;
            r_int_out      <= w_int_out_d;
            r_irr_clear    <= w_isr_set;
            r_vector_out   <= w_vector_out_d;
            r_vector_valid <= w_vector_valid_d;
            r_level        <= w_level_d;
            r_spurious     <= w_spurious_d;
        end
    end

    assign bus.int_out      = r_int_out;
    assign bus.isr          = r_isr;
    assign bus.irr_clear    = r_irr_clear;
    assign bus.vector_out   = r_vector_out;
    assign bus.vector_valid = r_vector_valid;

endmodule

// File: tb/tb_pic_service_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pic_service_sequencer
// Directed and randomized bench for pic_service_sequencer. Expected values come
// from a priority-rank reference model of the ISR, pointer and rotate flag.
// ---------------------------------------------------------------------------
module tb_pic_service_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pic_service_sequencer_if bus ();

    pic_service_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] m_isr;
    int         m_ptr;
    bit         m_rot;

    // 0 = highest priority
    function automatic int rank(input int lvl, input int ptr);
        return (lvl - ptr - 1 + 16) % 8;
    endfunction

    // Level of the best candidate that outranks every blocking level, else -1.
    function automatic int m_pick(input logic [7:0] cand, input logic [7:0] blk, input int ptr);
        int best;
        int best_rank;
        int blk_rank;
        best      = -1;
        best_rank = 8;
        blk_rank  = 8;
        for (int l = 0; l < 8; l++) begin
            if (cand[l] && rank(l, ptr) < best_rank) begin
                best      = l;
                best_rank = rank(l, ptr);
            end
            if (blk[l] && rank(l, ptr) < blk_rank) begin
                blk_rank = rank(l, ptr);
            end
        end
        return (best_rank < blk_rank) ? best : -1;
    endfunction

    function automatic logic [7:0] m_blocking();
        return bus.special_mask_mode ? (m_isr & ~bus.imr) : m_isr;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        m_isr = 8'h00;
        m_ptr = 7;
        m_rot = 1'b0;
    endtask

    task automatic check_int(input string tag);
        int w;
        tick();
        tick();
        w = m_pick(bus.irr & ~bus.imr, m_blocking(), m_ptr);
        check({tag, "_int_out"}, 32'(bus.int_out), 32'(w >= 0));
    endtask

    task automatic do_ocw2(input logic [2:0] cmd, input logic [2:0] lvl);
        int hi;
        bus.ocw2_strobe = 1'b1;
        bus.ocw2_cmd    = cmd;
        bus.ocw2_level  = lvl;
        tick();
        bus.ocw2_strobe = 1'b0;
        hi = m_pick(m_isr, 8'h00, m_ptr);
        case (cmd)
            3'b001: if (hi >= 0) m_isr[hi] = 1'b0;
            3'b101: if (hi >= 0) begin m_isr[hi] = 1'b0; m_ptr = hi; end
            3'b011: m_isr[lvl] = 1'b0;
            3'b111: begin m_isr[lvl] = 1'b0; m_ptr = int'(lvl); end
            3'b110: m_ptr = int'(lvl);
            3'b100: m_rot = 1'b1;
            3'b000: m_rot = 1'b0;
            default: ;
        endcase
        check("ocw2_isr", 32'(bus.isr), 32'(m_isr));
    endtask

    // Full two-pulse INTA sequence; the bench plays the request register and
    // drops the acknowledged irr bit.
    task automatic do_ack(input string tag);
        int         w;
        int         lvl;
        bit         spur;
        logic [7:0] clr;
        logic [7:0] exp_vec;
        w    = m_pick(bus.irr & ~bus.imr, m_blocking(), m_ptr);
        spur = (w < 0);
        lvl  = spur ? 7 : w;
        clr  = spur ? 8'h00 : (8'h01 << lvl);
        m_isr = m_isr | clr;
        exp_vec = {bus.vector_base, lvl[2:0]};

        bus.inta_n = 1'b0;
        tick();
        check({tag, "_isr_set"}, 32'(bus.isr), 32'(m_isr));
        check({tag, "_irr_clear"}, 32'(bus.irr_clear), 32'(clr));
        bus.irr = bus.irr & ~clr;
        tick();
        check({tag, "_irr_clear_1cyc"}, 32'(bus.irr_clear), 32'h0);
        check({tag, "_int_drop"}, 32'(bus.int_out), 32'h0);
        bus.inta_n = 1'b1;
        tick();
        tick();
        bus.inta_n = 1'b0;
        tick();
        check({tag, "_vector"}, 32'(bus.vector_out), 32'(exp_vec));
        check({tag, "_valid_hi"}, 32'(bus.vector_valid), 32'h1);
        tick();
        check({tag, "_valid_hold"}, 32'(bus.vector_valid), 32'h1);
        bus.inta_n = 1'b1;
        tick();
        if (bus.aeoi_mode && !spur) begin
            m_isr = m_isr & ~clr;
            if (m_rot) m_ptr = lvl;
        end
        check({tag, "_valid_lo"}, 32'(bus.vector_valid), 32'h0);
        check({tag, "_isr_end"}, 32'(bus.isr), 32'(m_isr));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                 = 1'b1;
        bus.init_strobe       = 1'b0;
        bus.irr               = 8'h00;
        bus.imr               = 8'h00;
        bus.special_mask_mode = 1'b0;
        bus.aeoi_mode         = 1'b0;
        bus.vector_base       = 5'h11;
        bus.inta_n            = 1'b1;
        bus.ocw2_strobe       = 1'b0;
        bus.ocw2_cmd          = 3'b010;
        bus.ocw2_level        = 3'd0;
        model_init();
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("rst_isr", 32'(bus.isr), 32'h0);
        check("rst_int_out", 32'(bus.int_out), 32'h0);
        check("rst_irr_clear", 32'(bus.irr_clear), 32'h0);
        check("rst_vector_out", 32'(bus.vector_out), 32'h0);
        check("rst_vector_valid", 32'(bus.vector_valid), 32'h0);

        // Basic acknowledge: IR2 wins over IR5, vector 0x8A
        bus.irr = 8'h24;
        check_int("basic");
        do_ack("basic");
        check("basic_vec_8a", 32'(bus.vector_out), 32'h8A);

        // Nesting: IR5 blocked by in-service IR2, IR1 nests
        check_int("nest_ir5_blocked");
        bus.irr = bus.irr | 8'h02;
        check_int("nest_ir1");
        do_ack("nest");
        check("nest_isr_06", 32'(bus.isr), 32'h06);
        do_ocw2(3'b001, 3'd0);
        do_ocw2(3'b001, 3'd0);
        check("basic_eoi_isr0", 32'(bus.isr), 32'h0);
        check_int("nest_ir5_after_eoi");
        bus.irr = 8'h00;

        // Rotation: service IR3, rotate-on-EOI, IR4 beats IR0
        bus.irr = 8'h08;
        check_int("rot_ir3");
        do_ack("rot_ir3");
        do_ocw2(3'b101, 3'd0);
        bus.irr = 8'h11;
        check_int("rot_11");
        do_ack("rot_11");
        check("rot_ir4_wins", 32'(bus.vector_out[2:0]), 32'd4);
        do_ocw2(3'b001, 3'd0);
        bus.irr = 8'h00;

        // AEOI with rotate flag: IR6 retires itself and becomes lowest
        bus.aeoi_mode = 1'b1;
        do_ocw2(3'b100, 3'd0);
        bus.irr = 8'h40;
        check_int("aeoi_ir6");
        do_ack("aeoi_ir6");
        check("aeoi_isr0", 32'(bus.isr), 32'h0);
        bus.irr = 8'h81;
        check_int("aeoi_81");
        do_ack("aeoi_81");
        check("aeoi_ir7_wins", 32'(bus.vector_out[2:0]), 32'd7);
        bus.aeoi_mode = 1'b0;
        do_ocw2(3'b000, 3'd0);
        bus.irr = 8'h00;

        // Spurious acknowledge
        bus.irr = 8'h02;
        check_int("spur_pre");
        bus.irr = 8'h00;
        do_ack("spur");
        check("spur_vec", 32'(bus.vector_out), 32'h8F);

        // Abort in GAP with init_strobe, then pointer back at 7
        do_ocw2(3'b110, 3'd2);
        bus.irr = 8'h08;
        check_int("abort_pre");
        bus.inta_n = 1'b0;
        tick();
        bus.inta_n = 1'b1;
        tick();
        tick();
        bus.init_strobe = 1'b1;
        tick();
        bus.init_strobe = 1'b0;
        model_init();
        check("abort_isr", 32'(bus.isr), 32'h0);
        check("abort_valid", 32'(bus.vector_valid), 32'h0);
        check("abort_int", 32'(bus.int_out), 32'h0);
        bus.irr = 8'h81;
        check_int("abort_post");
        do_ack("abort_post");
        check("abort_ptr7_ir0", 32'(bus.vector_out[2:0]), 32'd0);

        // Special mask mode: masked in-service IR0 stops blocking IR4
        bus.imr = 8'h01;
        bus.irr = 8'h10;
        check_int("smm_off");
        bus.special_mask_mode = 1'b1;
        check_int("smm_on");
        do_ack("smm");
        check("smm_isr_11", 32'(bus.isr), 32'h11);
        do_ocw2(3'b011, 3'd4);
        do_ocw2(3'b011, 3'd0);
        bus.special_mask_mode = 1'b0;
        bus.imr = 8'h00;
        bus.irr = 8'h00;

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            bus.vector_base       = 5'($urandom);
            bus.irr               = 8'($urandom);
            bus.imr               = 8'($urandom) & 8'($urandom);
            bus.special_mask_mode = ($urandom_range(0, 3) == 0);
            bus.aeoi_mode         = 1'($urandom_range(0, 1));
            check_int("rnd");
            do_ack("rnd");
            repeat ($urandom_range(0, 2)) do_ocw2(3'($urandom), 3'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
